// File: rtl/apple_iie_timing_pkg.sv
// Shared constants and tick decode for the Apple IIe bus-cycle timing generator.
// Build option: APPLE_IIE_PAL_EN selects the 312-line PAL frame instead of 262-line NTSC.
package apple_iie_timing_pkg;

  localparam int V_LINES_NTSC = 262;
  localparam int V_LINES_PAL  = 312;
  localparam int HALF_LEN     = 7;
  localparam int LONG_EXT     = 2;
  localparam int Q3_LAST      = 3;
  localparam int AX_LAST      = 2;
  localparam int RAS_FIRST    = 2;
  localparam int CAS_FIRST    = 4;

`ifdef APPLE_IIE_PAL_EN
  localparam int V_LINES = V_LINES_PAL;
`else
  localparam int V_LINES = V_LINES_NTSC;
`endif

  typedef struct packed {
    logic phi_0;
    logic q3;
    logic ax;
    logic pras_n;
    logic pcas_n;
  } strobe_t;

  // Ticks past the second half are the long-cycle stretch: CPU data phase held.
  function automatic strobe_t decode_tick(input logic [3:0] t);
    strobe_t    s;
    logic [3:0] k;
    s = '0;
    k = '0;
    if (t >= 4'(2*HALF_LEN)) begin
      s.phi_0  = 1'b1;
      s.q3     = 1'b0;
      s.ax     = 1'b0;
      s.pras_n = 1'b0;
      s.pcas_n = 1'b0;
    end else begin
      s.phi_0  = (t >= 4'(HALF_LEN));
      k        = s.phi_0 ? t - 4'(HALF_LEN) : t;
      s.q3     = (k <= 4'(Q3_LAST));
      s.ax     = (k <= 4'(AX_LAST));
      s.pras_n = !(k >= 4'(RAS_FIRST));
      s.pcas_n = !(k >= 4'(CAS_FIRST));
    end
    return s;
  endfunction

endpackage

// File: rtl/apple_iie_scan_counter.sv
// Horizontal/vertical scan counters with blanking and frame-start flags,
// advanced by the cycle-end enable from the tick sequencer.
import apple_iie_timing_pkg::*;

module apple_iie_scan_counter #(
  parameter int H_CYCLES  = 65,
  parameter int H_BLANK   = 25,
  parameter int V_DISPLAY = 192,
  parameter int V_LINES_P = V_LINES
) (
  input  logic       clk_14m,
  input  logic       reset,
  input  logic       cycle_end,
  output logic [6:0] h_count,
  output logic [8:0] v_count,
  output logic       long_cycle,
  output logic       hbl,
  output logic       vbl,
  output logic       frame_start
);

  logic [6:0] h_nxt;
  logic [8:0] v_nxt;

  always_comb begin
    h_nxt = h_count;
    v_nxt = v_count;
    if (cycle_end) begin
      if (h_count == 7'(H_CYCLES-1)) begin
        h_nxt = '0;
        v_nxt = (v_count == 9'(V_LINES_P-1)) ? '0 : v_count + 9'd1;
      end else begin
        h_nxt = h_count + 7'd1;
      end
    end
  end

  // Flags decode the next state so they line up with the counters they describe.
  always_ff @(posedge clk_14m) begin
    if (reset) begin
      h_count     <= '0;
      v_count     <= '0;
      long_cycle  <= 1'b0;
      hbl         <= 1'b1;
      vbl         <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      long_cycle  <= (h_nxt == 7'(H_CYCLES-1));
      hbl         <= (h_nxt < 7'(H_BLANK));
      vbl         <= (v_nxt >= 9'(V_DISPLAY));
      frame_start <= cycle_end && (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule

// File: rtl/apple_iie_timing_generator.sv
// Apple IIe master bus-cycle sequencer: Phi0/Phi1, Q3, 7M, RAM strobes and scan counters.
// Build option: APPLE_IIE_PAL_EN (PAL frame length, via the package).
import apple_iie_timing_pkg::*;

module apple_iie_timing_generator #(
  parameter int H_CYCLES  = 65,
  parameter int H_BLANK   = 25,
  parameter int V_DISPLAY = 192
) (
  input  logic       clk_14m,
  input  logic       reset,
  output logic       clk_phi_0,
  output logic       clk_phi_1,
  output logic       clk_q3,
  output logic       clk_7m,
  output logic       pras_n,
  output logic       pcas_n,
  output logic       ax,
  output logic       long_cycle,
  output logic [6:0] h_count,
  output logic [8:0] v_count,
  output logic       hbl,
  output logic       vbl,
  output logic       frame_start
);

  localparam logic [3:0] T_LAST      = 4'(2*HALF_LEN-1);
  localparam logic [3:0] T_LAST_LONG = 4'(2*HALF_LEN+LONG_EXT-1);

  logic [3:0] t, t_nxt;
  logic       cycle_end;
  strobe_t    s_nxt;

  // long_cycle already reflects the current h_count, so it selects the cycle length.
  assign cycle_end = (t == (long_cycle ? T_LAST_LONG : T_LAST));
  assign t_nxt     = cycle_end ? 4'd0 : t + 4'd1;
  assign s_nxt     = decode_tick(t_nxt);

  always_ff @(posedge clk_14m) begin
    if (reset) begin
      t         <= '0;
      clk_phi_0 <= 1'b0;
      clk_phi_1 <= 1'b1;
      clk_q3    <= 1'b1;
      ax        <= 1'b1;
      pras_n    <= 1'b1;
      pcas_n    <= 1'b1;
      clk_7m    <= 1'b0;
    end else begin
      t         <= t_nxt;
      clk_phi_0 <= s_nxt.phi_0;
      clk_phi_1 <= ~s_nxt.phi_0;
      clk_q3    <= s_nxt.q3;
      ax        <= s_nxt.ax;
      pras_n    <= s_nxt.pras_n;
      pcas_n    <= s_nxt.pcas_n;
      clk_7m    <= ~clk_7m;
    end
  end

  apple_iie_scan_counter #(
    .H_CYCLES  (H_CYCLES),
    .H_BLANK   (H_BLANK),
    .V_DISPLAY (V_DISPLAY),
    .V_LINES_P (V_LINES)
  ) u_scan (
    .clk_14m     (clk_14m),
    .reset       (reset),
    .cycle_end   (cycle_end),
    .h_count     (h_count),
    .v_count     (v_count),
    .long_cycle  (long_cycle),
    .hbl         (hbl),
    .vbl         (vbl),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_apple_iie_timing_generator.sv
// Scoreboard bench: full-size instance for line timing, short-line instance for frame wrap.
module tb_apple_iie_timing_generator;

`ifdef APPLE_IIE_PAL_EN
  localparam int VL = 312;
`else
  localparam int VL = 262;
`endif
  localparam int HB_CYC = 8;
  localparam int HB_LINE = HB_CYC*14+2;

  logic clk_14m = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_14m = ~clk_14m;

  logic       phi0_a, phi1_a, q3_a, c7_a, ras_a, cas_a, ax_a, long_a, hbl_a, vbl_a, fs_a;
  logic [6:0] h_a;
  logic [8:0] v_a;
  logic       phi0_b, phi1_b, q3_b, c7_b, ras_b, cas_b, ax_b, long_b, hbl_b, vbl_b, fs_b;
  logic [6:0] h_b;
  logic [8:0] v_b;

  apple_iie_timing_generator dut_a (
    .clk_14m(clk_14m), .reset(reset), .clk_phi_0(phi0_a), .clk_phi_1(phi1_a), .clk_q3(q3_a),
    .clk_7m(c7_a), .pras_n(ras_a), .pcas_n(cas_a), .ax(ax_a), .long_cycle(long_a),
    .h_count(h_a), .v_count(v_a), .hbl(hbl_a), .vbl(vbl_a), .frame_start(fs_a));

  apple_iie_timing_generator #(.H_CYCLES(HB_CYC), .H_BLANK(3)) dut_b (
    .clk_14m(clk_14m), .reset(reset), .clk_phi_0(phi0_b), .clk_phi_1(phi1_b), .clk_q3(q3_b),
    .clk_7m(c7_b), .pras_n(ras_b), .pcas_n(cas_b), .ax(ax_b), .long_cycle(long_b),
    .h_count(h_b), .v_count(v_b), .hbl(hbl_b), .vbl(vbl_b), .frame_start(fs_b));

  logic [31:0] pack_a, pack_b;
  assign pack_a = {5'b0, phi0_a, phi1_a, q3_a, c7_a, ras_a, cas_a, ax_a, long_a, hbl_a, vbl_a, fs_a, h_a, v_a};
  assign pack_b = {5'b0, phi0_b, phi1_b, q3_b, c7_b, ras_b, cas_b, ax_b, long_b, hbl_b, vbl_b, fs_b, h_b, v_b};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs from the absolute clock count since reset, laid out on the frame.
  function automatic logic [31:0] model(input int n, input int hc, input int hb);
    int line, p, v, r, h, t, k;
    logic phi0, q3, axv, ras, cas;
    line = hc*14 + 2;
    p = n % (VL*line);
    v = p / line;
    r = p % line;
    if (r < (hc-1)*14) begin h = r / 14; t = r % 14; end
    else begin h = hc-1; t = r - (hc-1)*14; end
    phi0 = (t >= 7);
    if (t >= 14) begin q3 = 0; axv = 0; ras = 0; cas = 0; end
    else begin
      k = phi0 ? t-7 : t;
      q3 = (k <= 3); axv = (k <= 2); ras = (k < 2); cas = (k < 4);
    end
    return {5'b0, phi0, !phi0, q3, 1'(n % 2), ras, cas, axv, (h == hc-1), (h < hb), (v >= 192),
            (p == 0), 7'(h), 9'(v)};
  endfunction

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  initial begin
    int  n;
    bit  armed;
    n = 0;
    armed = 0;
    forever begin
      @(posedge clk_14m);
      if (reset) begin n = 0; armed = 1; end
      else n++;
      if (armed) begin
        qa.push_back(model(n, 65, 25));
        qb.push_back(model(n, HB_CYC, 3));
      end
      @(negedge clk_14m);
      if (qa.size() > 0) begin
        chk("outs_a", pack_a, qa.pop_front());
        chk("outs_b", pack_b, qb.pop_front());
      end
    end
  end

  initial begin
    int cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk_14m);
    reset = 1'b0;
    for (int i = 0; i < 911 && n_err < 200; i++) @(negedge clk_14m);
    // Last tick of the stretched cycle of line 0.
    chk("long_h", 32'(h_a), 32'd64);
    chk("long_flag", 32'(long_a), 32'd1);
    chk("long_phi0", 32'(phi0_a), 32'd1);
    chk("long_q3", 32'(q3_a), 32'd0);
    reset = 1'b1;
    @(negedge clk_14m);
    reset = 1'b0;
    chk("rst_h", 32'(h_a), 32'd0);
    chk("rst_phi0", 32'(phi0_a), 32'd0);
    chk("rst_q3", 32'(q3_a), 32'd1);
    chk("rst_long", 32'(long_a), 32'd0);
    chk("rst_fs", 32'(fs_a), 32'd1);
    cnt = 0;
    do begin
      @(negedge clk_14m);
      cnt++;
    end while (!fs_b && cnt < 40000 && n_err < 200);
    chk("fs_period_b", 32'(cnt), 32'(VL*HB_LINE));
    chk("v_a_mid", 32'(v_a), 32'(cnt / 912));
    repeat (5) @(negedge clk_14m);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
